// File: rtl/cat_mac_sequencer.sv
// Sequencer for one CatRecognizer pass: streams N_INPUTS pixel/weight reads, multiply-accumulates, adds bias, thresholds.
// Optional build macro CAT_MAC_SATURATE_EN clamps accumulate and bias add instead of wrapping.
module cat_mac_sequencer #(
    parameter int N_INPUTS = 4096,
    parameter int DATA_W   = 8,
    parameter int WGT_W    = 6,
    parameter int ACC_W    = 32,
    parameter int ADDR_W   = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [ACC_W-1:0]  bias,
    input  logic signed [ACC_W-1:0]  threshold,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        pixel_data,
    input  logic signed [WGT_W-1:0]  weight_data,
    output logic                     busy,
    output logic                     done,
    output logic signed [ACC_W-1:0]  score,
    output logic                     is_cat,
    output logic [1:0]               fsm_state
);

    localparam int PROD_W = DATA_W + WGT_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_INPUTS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    rd_en_q, rd_en_d;
    logic                    rd_en_pipe_q;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    is_cat_q, is_cat_d;
    logic signed [ACC_W-1:0] score_q, score_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] bias_q, bias_d;
    logic signed [ACC_W-1:0] thr_q, thr_d;

    logic signed [PROD_W-1:0] pixel_ext, weight_ext, prod;
    logic signed [ACC_W-1:0]  prod_acc, acc_step, final_sum;

    function automatic logic signed [ACC_W-1:0] acc_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        logic signed [ACC_W-1:0] s;
        s = a + b;
`ifdef CAT_MAC_SATURATE_EN
        // Overflow only when both operands share a sign the result does not.
        if ((a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1])) begin
            s = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
`endif
        return s;
    endfunction

    // Pixel is unsigned: a zero MSB makes it a non-negative signed operand.
    assign pixel_ext  = PROD_W'($signed({1'b0, pixel_data}));
    assign weight_ext = PROD_W'(weight_data);
    assign prod       = pixel_ext * weight_ext;
    assign prod_acc   = ACC_W'(prod);
    assign acc_step   = acc_add(acc_q, prod_acc);
    assign final_sum  = acc_add(acc_q, bias_q);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rd_en_d  = rd_en_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        score_d  = score_q;
        is_cat_d = is_cat_q;
        bias_d   = bias_q;
        thr_d    = thr_q;
        acc_d    = rd_en_pipe_q ? acc_step : acc_q;

        unique case (state_q)
            IDLE: begin
                // The done cycle is spent in IDLE; a start there is dropped.
                if (start && !done_q) begin
                    state_d = RUN;
                    bias_d  = bias;
                    thr_d   = threshold;
                    acc_d   = '0;
                    addr_d  = '0;
                    rd_en_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (addr_q == LAST_ADDR) begin
                    rd_en_d = 1'b0;
                    addr_d  = '0;
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                state_d = FINISH;
            end
            FINISH: begin
                score_d  = final_sum;
                is_cat_d = final_sum > thr_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            rd_en_q      <= 1'b0;
            rd_en_pipe_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            score_q      <= '0;
            is_cat_q     <= 1'b0;
            acc_q        <= '0;
            bias_q       <= '0;
            thr_q        <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rd_en_q      <= rd_en_d;
            rd_en_pipe_q <= rd_en_q;
            busy_q       <= busy_d;
            done_q       <= done_d;
            score_q      <= score_d;
            is_cat_q     <= is_cat_d;
            acc_q        <= acc_d;
            bias_q       <= bias_d;
            thr_q        <= thr_d;
        end
    end

    assign mem_rd_en = rd_en_q;
    assign mem_addr  = addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign score     = score_q;
    assign is_cat    = is_cat_q;
    assign fsm_state = state_q;

endmodule
